// File: rtl/bank_xbar_pkg.sv
// Shared helpers for the banked read crossbar: id-width functions and the
// return-pipe entry that tracks which port owns an in-flight bank read.
package bank_xbar_pkg;

  // Wide enough for the largest supported port count (32).
  localparam int MAX_PORT_W = 5;

  function automatic int port_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int bank_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                  vld;
    logic [MAX_PORT_W-1:0] port_id;
  } pipe_ent_t;

endpackage

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter: one-hot combinational grant, search starts just
// after the last winner; the pointer only moves when a grant is issued.
module rr_arbiter_n
  import bank_xbar_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = port_id_w(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          found;

  // First pass covers ports above the pointer, second pass wraps to port 0.
  always_comb begin
    gnt   = '0;
    win   = ptr;
    found = 1'b0;
    if (en) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (j > int'(ptr))) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          win    = PW'(j);
        end
      end
      for (int j = 0; j < N; j++) begin
        if (!found && req[j]) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          win    = PW'(j);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       ptr <= PW'(N - 1);
    else if (found) ptr <= win;
  end

endmodule

// File: rtl/bank_rr_xbar.sv
// Multi-bank read crossbar: bank decode, per-bank round-robin, registered
// bank reads and fixed-latency return routing to the winning port.
module bank_rr_xbar
  import bank_xbar_pkg::*;
#(
  parameter int NUM_BANKS          = 3,
  parameter int SIZE_BANKI         = 32,
  parameter int NUM_RD_PORTS       = 8,
  parameter int DATA_W             = 32,
  parameter int RD_LAT             = 1,
  parameter int SHIRINA_BANKI      = $clog2(SIZE_BANKI),
  parameter int SHIRINA_BANK_ID    = bank_id_w(NUM_BANKS),
  parameter int SHIRINA_VSEH_BANOK = SHIRINA_BANKI + SHIRINA_BANK_ID
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [NUM_RD_PORTS-1:0]                          req_vld,
  input  logic [NUM_RD_PORTS-1:0][SHIRINA_VSEH_BANOK-1:0]  req_adr,
  output logic [NUM_RD_PORTS-1:0]                          gnt,
  input  logic [NUM_BANKS-1:0]                             bank_rdy,
  output logic [NUM_BANKS-1:0]                             bank_re,
  output logic [NUM_BANKS-1:0][SHIRINA_BANKI-1:0]          bank_adr,
  input  logic [NUM_BANKS-1:0][DATA_W-1:0]                 bank_rdata,
  output logic [NUM_RD_PORTS-1:0]                          rsp_vld,
  output logic [NUM_RD_PORTS-1:0]                          rsp_err,
  output logic [NUM_RD_PORTS-1:0][DATA_W-1:0]              rsp_data
);

  localparam int NP  = NUM_RD_PORTS;
  localparam int NB  = NUM_BANKS;
  localparam int SBI = SHIRINA_BANK_ID;
  localparam int SL  = SHIRINA_BANKI;

  logic [NP-1:0][SBI-1:0] bid;
  logic [NP-1:0]          oor;
  logic [NB-1:0][NP-1:0]  breq;
  logic [NB-1:0][NP-1:0]  bgnt;

  always_comb begin
    bid  = '0;
    oor  = '0;
    breq = '0;
    for (int p = 0; p < NP; p++) begin
      bid[p] = req_adr[p][SHIRINA_VSEH_BANOK-1 -: SBI];
      oor[p] = req_vld[p] && (int'(bid[p]) >= NB);
      for (int b = 0; b < NB; b++)
        breq[b][p] = req_vld[p] && (int'(bid[p]) == b);
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_arb
    rr_arbiter_n #(.N(NP)) u_arb (
      .clk (clk),
      .rst (rst),
      .req (breq[b]),
      .en  (bank_rdy[b]),
      .gnt (bgnt[b])
    );
  end

  // Out-of-range requests bypass arbitration; a port hits at most one bank.
  always_comb begin
    gnt = oor;
    for (int b = 0; b < NB; b++) gnt = gnt | bgnt[b];
  end

  pipe_ent_t [NB-1:0]         win;
  logic      [NB-1:0][SL-1:0] win_adr;

  always_comb begin
    win     = '0;
    win_adr = '0;
    for (int b = 0; b < NB; b++) begin
      for (int p = 0; p < NP; p++) begin
        if (bgnt[b][p]) begin
          win[b].vld     = 1'b1;
          win[b].port_id = MAX_PORT_W'(p);
          win_adr[b]     = req_adr[p][SL-1:0];
        end
      end
    end
  end

  // Index 0 is the newest entry; index RD_LAT lines up with bank_rdata.
  pipe_ent_t [NB-1:0][RD_LAT:0] rpipe;
  logic      [NP-1:0][RD_LAT:0] epipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_re  <= '0;
      bank_adr <= '0;
      rpipe    <= '0;
      epipe    <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        bank_re[b] <= win[b].vld;
        if (win[b].vld) bank_adr[b] <= win_adr[b];
        rpipe[b] <= {rpipe[b][RD_LAT-1:0], win[b]};
      end
      for (int p = 0; p < NP; p++)
        epipe[p] <= {epipe[p][RD_LAT-1:0], oor[p]};
    end
  end

  logic [NP-1:0]             nxt_vld;
  logic [NP-1:0]             nxt_err;
  logic [NP-1:0][DATA_W-1:0] nxt_data;

  always_comb begin
    nxt_vld  = '0;
    nxt_err  = '0;
    nxt_data = '0;
    for (int p = 0; p < NP; p++) begin
      nxt_err[p] = epipe[p][RD_LAT];
      for (int b = 0; b < NB; b++) begin
        if (rpipe[b][RD_LAT].vld && (rpipe[b][RD_LAT].port_id == MAX_PORT_W'(p))) begin
          nxt_vld[p]  = 1'b1;
          nxt_data[p] = bank_rdata[b];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_vld  <= '0;
      rsp_err  <= '0;
      rsp_data <= '0;
    end else begin
      rsp_vld  <= nxt_vld | nxt_err;
      rsp_err  <= nxt_err;
      rsp_data <= nxt_data;
    end
  end

endmodule

// File: tb/tb_bank_rr_xbar.sv
// Directed bench for bank_rr_xbar (3 banks, 12 ports, RD_LAT=3): the stimulus
// pushes expected responses into per-port queues, a negedge monitor pops them.
module tb_bank_rr_xbar;

  localparam int NP  = 12;
  localparam int NB  = 3;
  localparam int DW  = 32;
  localparam int RL  = 3;
  localparam int SL  = 5;
  localparam int SVB = 7;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NP-1:0]          req_vld;
  logic [NP-1:0][SVB-1:0] req_adr;
  logic [NP-1:0]          gnt;
  logic [NB-1:0]          bank_rdy;
  logic [NB-1:0]          bank_re;
  logic [NB-1:0][SL-1:0]  bank_adr;
  logic [NB-1:0][DW-1:0]  bank_rdata;
  logic [NP-1:0]          rsp_vld;
  logic [NP-1:0]          rsp_err;
  logic [NP-1:0][DW-1:0]  rsp_data;

  bank_rr_xbar #(
    .NUM_BANKS(NB), .SIZE_BANKI(32), .NUM_RD_PORTS(NP), .DATA_W(DW), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_adr(req_adr), .gnt(gnt),
    .bank_rdy(bank_rdy), .bank_re(bank_re), .bank_adr(bank_adr),
    .bank_rdata(bank_rdata), .rsp_vld(rsp_vld), .rsp_err(rsp_err),
    .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          due;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[NP][$];

  function automatic logic [31:0] mem_val(input int b, input logic [4:0] a);
    return {8'hA0, 8'(b), 11'h0, a};
  endfunction

  function automatic logic [SVB-1:0] mk(input int b, input int a);
    return {2'(b), 5'(a)};
  endfunction

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Bank model: data appears RL cycles after the bank_re cycle.
  logic [RL-1:0][NB-1:0]         re_sr  = '0;
  logic [RL-1:0][NB-1:0][SL-1:0] adr_sr = '0;
  always @(posedge clk) begin
    re_sr  <= {re_sr[RL-2:0], bank_re};
    adr_sr <= {adr_sr[RL-2:0], bank_adr};
  end
  always_comb begin
    for (int b = 0; b < NB; b++)
      bank_rdata[b] = re_sr[RL-1][b] ? mem_val(b, adr_sr[RL-1][b]) : 32'hDEADBEEF;
  end

  // Monitor
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        if (rsp_vld[p]) begin
          chk(exp_q[p].size() != 0, $sformatf("rsp expected p%0d", p), 1, 0);
          if (exp_q[p].size() != 0) begin
            e = exp_q[p].pop_front();
            chk(e.due == cyc, $sformatf("rsp cycle p%0d", p), cyc, e.due);
            chk(rsp_err[p] == e.err, $sformatf("rsp_err p%0d", p), rsp_err[p], e.err);
            chk(rsp_data[p] == e.data, $sformatf("rsp_data p%0d", p), rsp_data[p], e.data);
          end
        end else if (exp_q[p].size() != 0) begin
          if (exp_q[p][0].due <= cyc) begin
            chk(rsp_vld[p], $sformatf("rsp missing p%0d", p), 0, 1);
            void'(exp_q[p].pop_front());
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the next negedge after checking bank side.
  task automatic step(input logic [NP-1:0] v, input logic [NB-1:0] rdy,
                      input logic [NP-1:0] eg, input logic [NB-1:0] ere, input string nm);
    exp_t                 e;
    logic [1:0]           bk;
    logic [NB-1:0][SL-1:0] eadr;
    eadr     = '0;
    req_vld  = v;
    bank_rdy = rdy;
    #2;
    chk(gnt == eg, {nm, " gnt"}, gnt, eg);
    for (int p = 0; p < NP; p++) begin
      if (eg[p]) begin
        bk     = req_adr[p][SVB-1 -: 2];
        e.due  = cyc + 2 + RL;
        e.err  = (bk >= 2'd3);
        e.data = e.err ? 32'h0 : mem_val(int'(bk), req_adr[p][SL-1:0]);
        exp_q[p].push_back(e);
        if (!e.err) eadr[bk] = req_adr[p][SL-1:0];
      end
    end
    @(negedge clk);
    chk(bank_re == ere, {nm, " bank_re"}, bank_re, ere);
    for (int b = 0; b < NB; b++)
      if (ere[b]) chk(bank_adr[b] == eadr[b], {nm, " bank_adr"}, bank_adr[b], eadr[b]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '1, '0, '0, "idle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst      = 1'b0;
    req_vld  = '0;
    req_adr  = '0;
    bank_rdy = '1;
    repeat (2) @(negedge clk);
    #1;
    chk(bank_re == '0,   "reset bank_re",  bank_re, 0);
    chk(bank_adr == '0,  "reset bank_adr", bank_adr, 0);
    chk(rsp_vld == '0,   "reset rsp_vld",  rsp_vld, 0);
    chk(rsp_err == '0,   "reset rsp_err",  rsp_err, 0);
    chk(rsp_data == '0,  "reset rsp_data", longint'(|rsp_data), 0);
    rst = 1'b1;
    @(negedge clk);

    // Parallel banks: port 0 -> bank 0 adr 7, port 1 -> bank 2 adr 31
    req_adr[0] = mk(0, 7);
    req_adr[1] = mk(2, 31);
    step(12'h003, 3'b111, 12'h003, 3'b101, "parallel");
    idle(1);

    // Fairness on bank 1: ports 0,3,5 requesting continuously
    req_adr[0] = mk(1, 1);
    req_adr[3] = mk(1, 3);
    req_adr[5] = mk(1, 5);
    step(12'h029, 3'b111, 12'h001, 3'b010, "fair0");
    step(12'h029, 3'b111, 12'h008, 3'b010, "fair3");
    step(12'h029, 3'b111, 12'h020, 3'b010, "fair5");
    step(12'h029, 3'b111, 12'h001, 3'b010, "fair0b");
    step(12'h029, 3'b111, 12'h008, 3'b010, "fair3b");
    step(12'h029, 3'b111, 12'h020, 3'b010, "fair5b");
    idle(1);

    // Backpressure on bank 1 (pointer at 5): ports 2,4 wait, then 2 wins first
    req_adr[2] = mk(1, 2);
    req_adr[4] = mk(1, 4);
    for (int i = 0; i < 4; i++) step(12'h014, 3'b101, 12'h000, 3'b000, "stall");
    step(12'h014, 3'b111, 12'h004, 3'b010, "release2");
    step(12'h010, 3'b111, 12'h010, 3'b010, "release4");
    idle(1);

    // Out-of-range bank 3 on port 6, granted even with every bank stalled
    req_adr[6] = mk(3, 9);
    step(12'h040, 3'b000, 12'h040, 3'b000, "oor");
    idle(1);

    // Wrap on bank 0: port 11 wins, next search starts at port 0
    req_adr[11] = mk(0, 12);
    req_adr[0]  = mk(0, 20);
    req_adr[10] = mk(0, 10);
    step(12'h800, 3'b111, 12'h800, 3'b001, "wrap11");
    step(12'hC01, 3'b111, 12'h001, 3'b001, "wrap0");
    step(12'hC00, 3'b111, 12'h400, 3'b001, "wrap10");
    step(12'h800, 3'b111, 12'h800, 3'b001, "wrap11b");

    // Mid-traffic reset: port 3 -> bank 2 in flight, then async assert
    req_adr[3] = mk(2, 4);
    step(12'h008, 3'b111, 12'h008, 3'b100, "pre_rst");
    #1;
    rst     = 1'b0;
    req_vld = '0;
    #1;
    chk(bank_re == '0,  "midrst bank_re",  bank_re, 0);
    chk(bank_adr == '0, "midrst bank_adr", bank_adr, 0);
    chk(rsp_vld == '0,  "midrst rsp_vld",  rsp_vld, 0);
    chk(rsp_data == '0, "midrst rsp_data", longint'(|rsp_data), 0);
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    idle(6);

    // After reset bank 2 pointer is back at 11: port 0 beats port 5
    req_adr[0] = mk(2, 0);
    req_adr[5] = mk(2, 5);
    step(12'h021, 3'b111, 12'h001, 3'b100, "post_rst0");
    step(12'h020, 3'b111, 12'h020, 3'b100, "post_rst5");
    idle(8);

    for (int p = 0; p < NP; p++)
      chk(exp_q[p].size() == 0, $sformatf("drain p%0d", p), exp_q[p].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bank_rr_xbar.md
# bank_rr_xbar

Parametrised multi-bank read crossbar that replaces per-bank fixed 8-port arbiters with a generic NUM_RD_PORTS-wide scheme. Each read port presents a full (bank + local) address; the block decodes the bank, runs an independent round-robin arbiter per bank, issues registered bank reads and routes the returning data back to the winning port with fixed latency. Sits between the CPU read ports and the NUM_BANKS memory banks.

## Interface
- NUM_BANKS, 3, number of banks (1..8)
- SIZE_BANKI, 32, words per bank; power of two
- NUM_RD_PORTS, 8, read ports (2..32, no upper restriction from arbiter)
- DATA_W, 32, read data width
- RD_LAT, 1, bank read latency in cycles (bank_re to bank_rdata), ≥1
- SHIRINA_BANKI, $clog2(SIZE_BANKI), local address width
- SHIRINA_BANK_ID, max(1,$clog2(NUM_BANKS)), bank-index field width
- SHIRINA_VSEH_BANOK, SHIRINA_BANKI+SHIRINA_BANK_ID, full address width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_vld  in  [NUM_RD_PORTS]  port p requests a read
- req_adr  in  [NUM_RD_PORTS][SHIRINA_VSEH_BANOK]  full address; upper SHIRINA_BANK_ID bits = bank, lower = local
- gnt  out  [NUM_RD_PORTS]  combinational accept; transfer happens on req_vld&gnt
- bank_rdy  in  [NUM_BANKS]  bank may accept a read this cycle
- bank_re  out  [NUM_BANKS]  registered read enable
- bank_adr  out  [NUM_BANKS][SHIRINA_BANKI]  registered local address
- bank_rdata  in  [NUM_BANKS][DATA_W]  read data, valid RD_LAT cycles after bank_re
- rsp_vld  out  [NUM_RD_PORTS]  registered response strobe
- rsp_err  out  [NUM_RD_PORTS]  response is for an out-of-range bank index
- rsp_data  out  [NUM_RD_PORTS][DATA_W]  response data; 0 when rsp_err

## Operation
- Decode: bank_id = req_adr[p][MSBs]. bank_id ≥ NUM_BANKS → out-of-range request.
- Per bank b: candidate set = ports with req_vld and bank_id==b. If bank_rdy[b], round-robin picks one; gnt asserted to it. If !bank_rdy[b], no grant, pointer frozen.
- Round-robin: per-bank last_gnt pointer; search starts at last_gnt+1 mod NUM_RD_PORTS, wraps. Pointer updates to winner only on grant. Reset value NUM_RD_PORTS-1 (port 0 highest priority after reset).
- Out-of-range requests: granted unconditionally same cycle (no arbitration, no bank access); response returns with rsp_err=1, rsp_data=0.
- Each port targets one bank per cycle → at most one gnt per port per cycle; no response collisions since all paths share one latency.
- Return routing: per bank, a RD_LAT+1 deep shift pipe of {valid, port_id} tracks in-flight reads; per port, RD_LAT+1 deep err pipe.
- Reset (async assert): pointers to NUM_RD_PORTS-1, pipes cleared; in-flight reads dropped, no responses after reset; bank_re, bank_adr, rsp_vld, rsp_err, rsp_data all 0.

## Timing
- Cycle N: req_vld & gnt high (gnt depends on req_vld, req_adr, bank_rdy, pointer).
- Cycle N+1: bank_re[b]=1, bank_adr[b]=local address.
- Cycle N+1+RD_LAT: bank_rdata[b] valid.
- Cycle N+2+RD_LAT: rsp_vld[p]=1, rsp_data[p] registered from bank_rdata. Err path: rsp_vld/rsp_err at N+2+RD_LAT too.
- Throughput: one read per bank per cycle; back-to-back grants allowed; full pipelining.
- Port without gnt must hold req_vld and req_adr stable.

## Structure
- Package bank_xbar_pkg: port-id / bank-id width helper functions, pipe-entry struct {vld, port_id}.
- Sub-module rr_arbiter_n (parameter N): req[N], en, gnt[N] one-hot combinational, internal registered pointer; instantiated NUM_BANKS times via generate.
- Top holds decode, bank output registers, return pipes and response muxing.

## Test plan
- Reset: rst low mid-traffic → all outputs 0 next edge-free; no rsp_vld for pre-reset grants; first grant after release to port 0.
- Fairness: ports 0,3,5 hold req to bank 1 continuously → grants 0,3,5,0,3,5; one bank_re per cycle.
- Parallel banks: port 0→bank 0 adr 7, port 1→bank 2 adr 31 same cycle → both granted, bank_re=3'b101, rsp_vld both at N+2+RD_LAT with correct data.
- Backpressure: bank_rdy[1]=0 for 4 cycles with ports 2,4 requesting → no gnt, pointer frozen; on release port 2 granted first, then 4.
- Out-of-range: NUM_BANKS=3, port 6 adr bank field 3 → gnt same cycle, rsp_vld & rsp_err at N+2+RD_LAT, rsp_data=0, no bank_re.
- Wrap/params: NUM_RD_PORTS=12, RD_LAT=3, last grant port 11 → next search starts at port 0; latency check rsp at N+5.
